// File: rtl/circle_pkg.sv
// Shared definitions for the circle rasteriser: controller states,
// the 3-bit RGB palette used by the VGA adapter, and default screen size.
package circle_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        INIT   = 3'd1,
        PLOT   = 3'd2,
        STEP   = 3'd3,
        FINISH = 3'd4
    } state_t;

    localparam int DEFAULT_SCREEN_WIDTH  = 160;
    localparam int DEFAULT_SCREEN_HEIGHT = 120;

    // Colour bits are {R, G, B}
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] BLUE   = 3'b001;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic [2:0] YELLOW = 3'b110;
    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] WHITE  = 3'b111;

endpackage

// File: rtl/raster_clip.sv
// Signed visibility test for one candidate pixel against the raster limits.
module raster_clip #(
    parameter int XW            = 8,
    parameter int YW            = 7,
    parameter int SCREEN_WIDTH  = 160,
    parameter int SCREEN_HEIGHT = 120
) (
    input  logic signed [XW+1:0] px_i,
    input  logic signed [YW+1:0] py_i,
    output logic                 in_bounds_o
);

    localparam logic signed [XW+1:0] X_LIM = (XW+2)'(SCREEN_WIDTH);
    localparam logic signed [YW+1:0] Y_LIM = (YW+2)'(SCREEN_HEIGHT);
    localparam logic signed [XW+1:0] X_ZERO = '0;
    localparam logic signed [YW+1:0] Y_ZERO = '0;

    // Pixel is visible only when both coordinates lie inside [0, limit)
    always_comb begin
        in_bounds_o = 1'b0;
        if ((px_i >= X_ZERO) && (px_i < X_LIM) && (py_i >= Y_ZERO) && (py_i < Y_LIM)) begin
            in_bounds_o = 1'b1;
        end else begin
            in_bounds_o = 1'b0;
        end
    end

endmodule

// File: rtl/circle_raster.sv
// Midpoint circle rasteriser: walks one octant with the midpoint decision
// variable and emits either the 8 mirrored outline points or 4 horizontal
// spans per step, one pixel per clock, as registered plot strobes.
module circle_raster
    import circle_pkg::*;
#(
    parameter int XW            = 8,
    parameter int YW            = 7,
    parameter int RW            = 8,
    parameter int CW            = 3,
    parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT
) (
    input  logic          CLOCK_50,
    input  logic          resetn,
    input  logic          start,
    input  logic          fill,
    input  logic [XW-1:0] centerx,
    input  logic [YW-1:0] centery,
    input  logic [RW-1:0] radius,
    input  logic [CW-1:0] colour_in,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam int XS  = XW + 2;
    localparam int YS  = YW + 2;
    localparam int CRW = RW + 3;
    localparam logic signed [CRW-1:0] CRIT_ONE = CRW'(1);

    state_t                state_q, state_d;
    logic [XW-1:0]         cx_q, cx_d;
    logic [YW-1:0]         cy_q, cy_d;
    logic [RW-1:0]         r_q, r_d;
    logic [CW-1:0]         col_q, col_d;
    logic                  fill_q, fill_d;
    logic [RW-1:0]         ox_q, ox_d, oy_q, oy_d;
    logic signed [CRW-1:0] crit_q, crit_d;
    logic [2:0]            idx_q, idx_d;     // octant (outline) or span (fill)
    logic [RW:0]           cnt_q, cnt_d;     // pixel offset within a span
    logic [XW-1:0]         x_q, x_d;
    logic [YW-1:0]         y_q, y_d;
    logic [CW-1:0]         colour_q, colour_d;
    logic                  plot_q, plot_d, busy_q, busy_d, done_q, done_d;

    logic signed [XS-1:0]  cx_s, oxx_s, oyx_s, halfx_s, cntx_s, px_s;
    logic signed [YS-1:0]  cy_s, oxy_s, oyy_s, py_s;
    logic [RW-1:0]         half_s, oy_n_s, ox_n_s;
    logic [RW:0]           span_end_s;
    logic                  crit_le0_s, in_bounds_s;
    logic signed [CRW-1:0] oy_c_s, diff_c_s;

    assign cx_s       = XS'(cx_q);
    assign cy_s       = YS'(cy_q);
    assign oxx_s      = XS'(ox_q);
    assign oyx_s      = XS'(oy_q);
    assign oxy_s      = YS'(ox_q);
    assign oyy_s      = YS'(oy_q);
    // Spans A/B are half-width ox, spans C/D are half-width oy
    assign half_s     = idx_q[1] ? oy_q : ox_q;
    assign halfx_s    = idx_q[1] ? oyx_s : oxx_s;
    assign span_end_s = {half_s, 1'b0};
    assign cntx_s     = XS'(cnt_q);

    // Decision-variable update uses the already-advanced oy and ox
    assign crit_le0_s = crit_q[CRW-1] || (crit_q == '0);
    assign oy_n_s     = oy_q + RW'(1);
    assign ox_n_s     = crit_le0_s ? ox_q : (ox_q - RW'(1));
    assign oy_c_s     = $signed(CRW'(oy_n_s));
    assign diff_c_s   = oy_c_s - $signed(CRW'(ox_n_s));

    // Current candidate pixel for the active octant or span position
    always_comb begin
        px_s = cx_s;
        py_s = cy_s;
        if (fill_q) begin
            px_s = cx_s - halfx_s + cntx_s;
            case (idx_q[1:0])
                2'd0:    py_s = cy_s + oyy_s;
                2'd1:    py_s = cy_s - oyy_s;
                2'd2:    py_s = cy_s + oxy_s;
                default: py_s = cy_s - oxy_s;
            endcase
        end else begin
            case (idx_q)
                3'd0:    begin px_s = cx_s + oxx_s; py_s = cy_s + oyy_s; end
                3'd1:    begin px_s = cx_s + oyx_s; py_s = cy_s + oxy_s; end
                3'd2:    begin px_s = cx_s - oxx_s; py_s = cy_s + oyy_s; end
                3'd3:    begin px_s = cx_s - oyx_s; py_s = cy_s + oxy_s; end
                3'd4:    begin px_s = cx_s - oxx_s; py_s = cy_s - oyy_s; end
                3'd5:    begin px_s = cx_s - oyx_s; py_s = cy_s - oxy_s; end
                3'd6:    begin px_s = cx_s + oxx_s; py_s = cy_s - oyy_s; end
                default: begin px_s = cx_s + oyx_s; py_s = cy_s - oxy_s; end
            endcase
        end
    end

    raster_clip #(
        .XW(XW), .YW(YW), .SCREEN_WIDTH(SCREEN_WIDTH), .SCREEN_HEIGHT(SCREEN_HEIGHT)
    ) u_clip (
        .px_i(px_s), .py_i(py_s), .in_bounds_o(in_bounds_s)
    );

    // Controller next-state, datapath updates and next registered outputs
    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        r_d      = r_q;
        col_d    = col_q;
        fill_d   = fill_q;
        ox_d     = ox_q;
        oy_d     = oy_q;
        crit_d   = crit_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        x_d      = x_q;
        y_d      = y_q;
        colour_d = colour_q;
        plot_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    cx_d    = centerx;
                    cy_d    = centery;
                    r_d     = radius;
                    col_d   = colour_in;
                    fill_d  = fill;
                    state_d = INIT;
                end else begin
                    state_d = IDLE;
                end
            end
            INIT: begin
                ox_d    = r_q;
                oy_d    = '0;
                crit_d  = CRIT_ONE - $signed(CRW'(r_q));
                idx_d   = 3'd0;
                cnt_d   = '0;
                state_d = PLOT;
            end
            PLOT: begin
                x_d      = px_s[XW-1:0];
                y_d      = py_s[YW-1:0];
                colour_d = col_q;
                plot_d   = in_bounds_s;
                if (fill_q) begin
                    if (cnt_q == span_end_s) begin
                        cnt_d = '0;
                        if ((idx_q == 3'd3) || (r_q == '0)) begin
                            idx_d   = 3'd0;
                            state_d = STEP;
                        end else begin
                            idx_d = idx_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + (RW+1)'(1);
                    end
                end else begin
                    if ((idx_q == 3'd7) || (r_q == '0)) begin
                        idx_d   = 3'd0;
                        state_d = STEP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            STEP: begin
                oy_d = oy_n_s;
                ox_d = ox_n_s;
                if (crit_le0_s) begin
                    crit_d = crit_q + (oy_c_s <<< 1) + CRIT_ONE;
                end else begin
                    crit_d = crit_q + (diff_c_s <<< 1) + CRIT_ONE;
                end
                // A zero radius is a single point; never walk its octant
                if ((r_q == '0) || (oy_n_s > ox_n_s)) begin
                    state_d = FINISH;
                end else begin
                    state_d = PLOT;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        done_d = (state_d == FINISH);
    end

    // State, datapath and output registers with synchronous active-low reset
    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            r_q      <= '0;
            col_q    <= '0;
            fill_q   <= 1'b0;
            ox_q     <= '0;
            oy_q     <= '0;
            crit_q   <= '0;
            idx_q    <= 3'd0;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            colour_q <= '0;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            r_q      <= r_d;
            col_q    <= col_d;
            fill_q   <= fill_d;
            ox_q     <= ox_d;
            oy_q     <= oy_d;
            crit_q   <= crit_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            x_q      <= x_d;
            y_q      <= y_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_circle_raster.sv
// Self-checking bench for circle_raster: a behavioural midpoint-circle model
// produces the expected per-cycle plot stream, compared cycle by cycle.
module tb_circle_raster;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       fill;
    logic [7:0] centerx;
    logic [6:0] centery;
    logic [7:0] radius;
    logic [2:0] colour_in;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit p;
        int x;
        int y;
        bit d;
    } ent_t;

    ent_t q[$];

    always #10 clk = ~clk;

    circle_raster dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .start    (start),
        .fill     (fill),
        .centerx  (centerx),
        .centery  (centery),
        .radius   (radius),
        .colour_in(colour_in),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void push_pt(int px, int py);
        ent_t e;
        e.p = (px >= 0) && (px < 160) && (py >= 0) && (py < 120);
        e.x = px;
        e.y = py;
        e.d = 1'b0;
        q.push_back(e);
    endfunction

    function automatic void push_gap();
        ent_t e;
        e.p = 1'b0;
        e.x = 0;
        e.y = 0;
        e.d = 1'b0;
        q.push_back(e);
    endfunction

    function automatic void span(int row, int cx, int h);
        for (int c = cx - h; c <= cx + h; c++) push_pt(c, row);
    endfunction

    // Expected output stream: each step's pixels, then one idle cycle;
    // the idle cycle after the final step is the completion pulse.
    function automatic void build_model(int cx, int cy, int r, bit f);
        int ox;
        int oy;
        int crit;
        q.delete();
        ox = r;
        oy = 0;
        crit = 1 - r;
        while (1) begin
            if (r == 0) begin
                push_pt(cx, cy);
            end else if (!f) begin
                push_pt(cx + ox, cy + oy); push_pt(cx + oy, cy + ox);
                push_pt(cx - ox, cy + oy); push_pt(cx - oy, cy + ox);
                push_pt(cx - ox, cy - oy); push_pt(cx - oy, cy - ox);
                push_pt(cx + ox, cy - oy); push_pt(cx + oy, cy - ox);
            end else begin
                span(cy + oy, cx, ox); span(cy - oy, cx, ox);
                span(cy + ox, cx, oy); span(cy - ox, cx, oy);
            end
            push_gap();
            if (r == 0) break;
            oy++;
            if (crit <= 0) begin
                crit += 2 * oy + 1;
            end else begin
                ox--;
                crit += 2 * (oy - ox) + 1;
            end
            if (oy > ox) break;
        end
        q[q.size() - 1].d = 1'b1;
    endfunction

    task automatic scramble();
        centerx   = 8'($urandom);
        centery   = 7'($urandom);
        radius    = 8'($urandom);
        fill      = 1'($urandom);
        colour_in = 3'($urandom);
    endtask

    task automatic run_draw(input int cx, input int cy, input int r, input bit f,
                            input int col, input bit poke, output int plots);
        plots = 0;
        build_model(cx, cy, r, f);
        centerx   = 8'(cx);
        centery   = 7'(cy);
        radius    = 8'(r);
        fill      = f;
        colour_in = 3'(col);
        start     = 1'b1;
        tick();
        start = 1'b0;
        scramble();
        chk("busy_init", busy, 1);
        chk("plot_init", plot, 0);
        tick();
        chk("plot_init2", plot, 0);
        for (int i = 0; i < q.size(); i++) begin
            if (poke && (i == 2)) begin
                start = 1'b1;
                scramble();
            end else begin
                start = 1'b0;
            end
            tick();
            chk($sformatf("plot[%0d]", i), plot, q[i].p);
            if (q[i].p) begin
                plots++;
                chk($sformatf("x[%0d]", i), x, q[i].x);
                chk($sformatf("y[%0d]", i), y, q[i].y);
                chk($sformatf("colour[%0d]", i), colour, col);
            end
            chk($sformatf("done[%0d]", i), done, q[i].d);
            chk($sformatf("busy[%0d]", i), busy, 1);
        end
        start = 1'b0;
        tick();
        chk("busy_end", busy, 0);
        chk("done_end", done, 0);
        chk("plot_end", plot, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int stray;
        resetn    = 1'b0;
        start     = 1'b0;
        fill      = 1'b0;
        centerx   = 8'd33;
        centery   = 7'd44;
        radius    = 8'd5;
        colour_in = 3'd7;
        tick();
        tick();
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_colour", colour, 0);
        chk("rst_plot", plot, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        resetn = 1'b1;
        tick();

        // Single point for zero radius
        run_draw(80, 60, 0, 1'b0, 3'd4, 1'b0, n);
        chk("r0_plots", n, 1);

        // Radius 1 outline: two steps of eight points
        run_draw(80, 60, 1, 1'b0, 3'd2, 1'b0, n);
        chk("r1_plots", n, 16);

        // Radius 2 filled disc
        run_draw(80, 60, 2, 1'b1, 3'd1, 1'b0, n);
        chk("fill_r2_plots", n, 28);

        // Circle centred on the corner: three quarters clipped
        run_draw(0, 0, 10, 1'b0, 3'd7, 1'b0, n);

        // Start pulsed while busy must be ignored
        run_draw(70, 50, 6, 1'b0, 3'd6, 1'b1, n);
        run_draw(90, 40, 4, 1'b1, 3'd3, 1'b1, n);

        // Reset mid-draw aborts with no further plots or completion
        centerx   = 8'd80;
        centery   = 7'd60;
        radius    = 8'd5;
        fill      = 1'b0;
        colour_in = 3'd5;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        resetn = 1'b0;
        tick();
        resetn = 1'b1;
        chk("abort_plot", plot, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (plot || done || busy) stray++;
        end
        chk("abort_quiet", stray, 0);
        run_draw(80, 60, 3, 1'b0, 3'd2, 1'b0, n);

        // Randomised circles, including off-screen centres
        for (int k = 0; k < 8; k++) begin
            run_draw(int'($urandom_range(0, 200)), int'($urandom_range(0, 127)),
                     int'($urandom_range(0, 16)), 1'($urandom_range(0, 1)),
                     int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
